// File: rtl/hex_scan_sequencer_if.sv
// Bundle between the io_in pins and the hex scan sequencer:
// serial load, scan control, and segment/strobe outputs.
interface hex_scan_sequencer_if;
  logic       ser_in;
  logic       ser_valid;
  logic       commit;
  logic       freeze;
  logic       reverse;
  logic [6:0] seg;
  logic [1:0] digit_idx;
  logic       dp;
  logic       active;

  modport master (
    output ser_in, ser_valid, commit, freeze, reverse,
    input  seg, digit_idx, dp, active
  );

  modport slave (
    input  ser_in, ser_valid, commit, freeze, reverse,
    output seg, digit_idx, dp, active
  );
endinterface

// File: rtl/hex_scan_sequencer.sv
// Serial-loaded four-digit hex display scanner with dwell prescaler,
// freeze and reverse-order control; all outputs registered.
module hex_scan_sequencer #(
  parameter int DWELL   = 1024,
  parameter int DWELL_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_scan_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

  state_t             state, state_d;
  logic [15:0]        sr, sr_d;
  logic [15:0]        dbuf, dbuf_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [1:0]         idx, idx_d;
  logic [6:0]         seg, seg_d;
  logic               dp, dp_d;
  logic               active, active_d;
  logic [3:0]         nib;
  logic               wrap;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    unique case (idx)
      2'd0:    nib = dbuf[3:0];
      2'd1:    nib = dbuf[7:4];
      2'd2:    nib = dbuf[11:8];
      default: nib = dbuf[15:12];
    endcase
  end

  assign wrap = (cnt == LAST);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    dbuf_d   = dbuf;
    sr_d     = sr;
    if (bus.ser_valid)
      sr_d = {sr[14:0], bus.ser_in};
    // Commit wins over freeze and loads the pre-shift register
    if (bus.commit) begin
      dbuf_d  = sr;
      cnt_d   = '0;
      idx_d   = bus.reverse ? 2'd3 : 2'd0;
      state_d = SCAN;
    end else begin
      unique case (state)
        SCAN: begin
          if (wrap) begin
            cnt_d = '0;
            idx_d = bus.reverse ? idx - 2'd1 : idx + 2'd1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
          if (bus.freeze)
            state_d = HOLD;
        end
        HOLD: begin
          if (!bus.freeze)
            state_d = SCAN;
        end
        default: state_d = state;
      endcase
    end
  end

  always_comb begin
    seg_d    = (state == BLANK) ? 7'h00 : hex7(nib);
    active_d = (state != BLANK);
    dp_d     = (state != BLANK) && (idx == 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BLANK;
      sr     <= '0;
      dbuf   <= '0;
      cnt    <= '0;
      idx    <= '0;
      seg    <= '0;
      dp     <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_d;
      sr     <= sr_d;
      dbuf   <= dbuf_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      seg    <= seg_d;
      dp     <= dp_d;
      active <= active_d;
    end
  end

  assign bus.seg       = seg;
  assign bus.digit_idx = idx;
  assign bus.dp        = dp;
  assign bus.active    = active;

endmodule

// File: tb/tb_hex_scan_sequencer.sv
// Directed bench for hex_scan_sequencer with DWELL = 4.
// Word 0x1A8F: nibbles 0..3 = F,8,A,1 -> 71,7F,77,06.
module tb_hex_scan_sequencer;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  hex_scan_sequencer_if bus ();

  hex_scan_sequencer #(
    .DWELL   (4),
    .DWELL_W (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic disp(input string tag, input logic [1:0] i,
                      input logic [6:0] s, input logic d,
                      input logic a);
    chk({tag, ".idx"}, 32'(bus.digit_idx), 32'(i));
    chk({tag, ".seg"}, 32'(bus.seg), 32'(s));
    chk({tag, ".dp"}, 32'(bus.dp), 32'(d));
    chk({tag, ".act"}, 32'(bus.active), 32'(a));
  endtask

  task automatic shift_word(input logic [15:0] w);
    for (int b = 15; b >= 0; b--) begin
      bus.ser_in    = w[b];
      bus.ser_valid = 1'b1;
      tick(1);
    end
    bus.ser_valid = 1'b0;
    bus.ser_in    = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick(1);
    bus.commit = 1'b0;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    reset         = 1'b1;
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.commit    = 1'b0;
    bus.freeze    = 1'b0;
    bus.reverse   = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(50);
    disp("idle", 2'd0, 7'h00, 1'b0, 1'b0);

    // Forward scan
    shift_word(16'h1A8F);
    disp("blank_shift", 2'd0, 7'h00, 1'b0, 1'b0);
    do_commit();
    tick(1);
    disp("fwd0", 2'd0, 7'h71, 1'b1, 1'b1);
    tick(4);
    disp("fwd1", 2'd1, 7'h7F, 1'b0, 1'b1);
    tick(4);
    disp("fwd2", 2'd2, 7'h77, 1'b0, 1'b1);
    tick(4);
    disp("fwd3", 2'd3, 7'h06, 1'b0, 1'b1);
    tick(4);
    disp("fwd_wrap", 2'd0, 7'h71, 1'b1, 1'b1);

    // Reverse scan
    bus.reverse = 1'b1;
    do_commit();
    tick(1);
    disp("rev3", 2'd3, 7'h06, 1'b0, 1'b1);
    tick(4);
    disp("rev2", 2'd2, 7'h77, 1'b0, 1'b1);
    tick(4);
    disp("rev1", 2'd1, 7'h7F, 1'b0, 1'b1);
    tick(4);
    disp("rev0", 2'd0, 7'h71, 1'b1, 1'b1);
    tick(4);
    disp("rev_wrap", 2'd3, 7'h06, 1'b0, 1'b1);

    // Freeze at idx 2 with two dwell cycles already spent
    bus.reverse = 1'b0;
    do_commit();
    tick(9);
    disp("pre_frz", 2'd2, 7'h77, 1'b0, 1'b1);
    bus.freeze = 1'b1;
    tick(1);
    tick(20);
    disp("frz", 2'd2, 7'h77, 1'b0, 1'b1);
    bus.freeze = 1'b0;
    tick(2);
    chk("frz_rem.idx", 32'(bus.digit_idx), 32'd2);
    tick(1);
    chk("frz_adv.idx", 32'(bus.digit_idx), 32'd3);
    tick(1);
    disp("frz_adv", 2'd3, 7'h06, 1'b0, 1'b1);

    // Async reset mid-scan
    #3 reset = 1'b1;
    #1;
    disp("async_rst", 2'd0, 7'h00, 1'b0, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(3);
    disp("post_rst", 2'd0, 7'h00, 1'b0, 1'b0);

    // Commit and shift on one edge: buffer gets old sr = 0
    bus.ser_in    = 1'b1;
    bus.ser_valid = 1'b1;
    bus.commit    = 1'b1;
    tick(1);
    bus.ser_in    = 1'b0;
    bus.ser_valid = 1'b0;
    bus.commit    = 1'b0;
    tick(1);
    disp("cm_shift", 2'd0, 7'h3F, 1'b1, 1'b1);
    do_commit();
    tick(1);
    chk("sr_one.seg", 32'(bus.seg), 32'h06);

    // Shifting during scan leaves display alone
    shift_word(16'h1A8F);
    do_commit();
    tick(1);
    disp("scan_a", 2'd0, 7'h71, 1'b1, 1'b1);
    shift_word(16'h2222);
    tick(1);
    disp("scan_b", 2'd0, 7'h71, 1'b1, 1'b1);
    tick(4);
    disp("scan_c", 2'd1, 7'h7F, 1'b0, 1'b1);
    do_commit();
    tick(1);
    disp("new_word", 2'd0, 7'h5B, 1'b1, 1'b1);
    tick(4);
    disp("new_word1", 2'd1, 7'h5B, 1'b0, 1'b1);

    // Commit while frozen restarts, then freeze takes hold again
    bus.freeze = 1'b1;
    tick(3);
    bus.reverse = 1'b1;
    do_commit();
    tick(10);
    disp("frz_commit", 2'd3, 7'h5B, 1'b0, 1'b1);
    bus.freeze  = 1'b0;
    bus.reverse = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
